// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: ALUOp/funct decode, single-cycle ALU, and an
// iterative shift-add multiplier / restoring divider that owns HI/LO.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2;

  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                         F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                         F_SLT = 6'h2A, F_SLTU = 6'h2B, F_MFHI = 6'h10, F_MFLO = 6'h12,
                         F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d, div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic is_r, is_mult, is_multu, is_div, is_divu, is_muldiv, is_hilo, is_signed_op;
  assign is_r         = (ALUOp == 2'b10);
  assign is_mult      = is_r && (funct == F_MULT);
  assign is_multu     = is_r && (funct == F_MULTU);
  assign is_div       = is_r && (funct == F_DIV);
  assign is_divu      = is_r && (funct == F_DIVU);
  assign is_muldiv    = is_mult || is_multu || is_div || is_divu;
  assign is_hilo      = is_muldiv || (is_r && (funct == F_MFHI || funct == F_MFLO));
  assign is_signed_op = is_mult || is_div;

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_FIX);
  assign stall = op_valid && busy && is_hilo;
  assign hi    = hi_q;
  assign lo    = lo_q;

  logic [WIDTH-1:0] sum, diff;
  logic             add_ovf, sub_ovf;
  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (ALUOp)
      2'b00: begin result = sum;  overflow = add_ovf; end
      2'b01: begin result = diff; overflow = sub_ovf; end
      2'b11: result = a | b;
      default: begin
        case (funct)
          F_ADD:  begin result = sum;  overflow = add_ovf; end
          F_ADDU: result = sum;
          F_SUB:  begin result = diff; overflow = sub_ovf; end
          F_SUBU: result = diff;
          F_AND:  result = a & b;
          F_OR:   result = a | b;
          F_XOR:  result = a ^ b;
          F_NOR:  result = ~(a | b);
          F_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          F_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
          F_MFHI: result = hi_q;
          F_MFLO: result = lo_q;
          default: result = '0;
        endcase
      end
    endcase
  end

  assign zero = (result == '0);

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, rem_try, quo, rem;
  logic [WIDTH:0]   madd, dshift;
  logic [2*WIDTH-1:0] prod;
  assign a_neg   = is_signed_op && a[WIDTH-1];
  assign b_neg   = is_signed_op && b[WIDTH-1];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  // work_q is {acc, multiplier} for mult and {remainder, dividend/quotient} for div
  assign madd    = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{work_q[0]}}};
  assign dshift  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign rem_try = WIDTH'(dshift - {1'b0, opnd_q});
  assign prod    = neg_p_q ? -work_q : work_q;
  assign quo     = work_q[WIDTH-1:0];
  assign rem     = work_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid && is_muldiv && !stall) begin
          state_d  = S_RUN;
          cnt_d    = CNT_W'(WIDTH);
          is_div_d = is_div || is_divu;
          work_d   = {{WIDTH{1'b0}}, (is_div || is_divu) ? a_mag : b_mag};
          opnd_d   = (is_div || is_divu) ? b_mag : a_mag;
          neg_p_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          div0_d   = (b == '0);
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          if (dshift >= {1'b0, opnd_q}) work_d = {rem_try, work_q[WIDTH-2:0], 1'b1};
          else                          work_d = {dshift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
        end else begin
          work_d = {madd, work_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        // a zero divisor leaves the dividend magnitude in rem, so hi restores a
        if (is_div_q) begin
          lo_d = div0_q ? '1 : (neg_p_q ? -quo : quo);
          hi_d = neg_r_q ? -rem : rem;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (WIDTH = 32) against a plain-arithmetic model.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ALUOp = 2'b00;
  logic [5:0]  funct = 6'h00;
  logic        op_valid = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] result, hi, lo;
  logic        zero, overflow, stall, busy, done;

  int cmp_n = 0;
  int err_n = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ALUOp(ALUOp), .funct(funct), .op_valid(op_valid),
    .a(a), .b(b), .result(result), .zero(zero), .overflow(overflow),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic void model_alu(input logic [1:0] op, input logic [5:0] f,
                                    input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] h, input logic [31:0] l,
                                    output logic [31:0] r, output logic v);
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0;
    v = 1'b0;
    case (op)
      2'b00: begin s = sx + sy; r = x + y; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      2'b01: begin s = sx - sy; r = x - y; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      2'b11: r = x | y;
      default: begin
        case (f)
          6'h20: begin s = sx + sy; r = x + y; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
          6'h21: r = x + y;
          6'h22: begin s = sx - sy; r = x - y; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
          6'h23: r = x - y;
          6'h24: r = x & y;
          6'h25: r = x | y;
          6'h26: r = x ^ y;
          6'h27: r = ~(x | y);
          6'h2A: r = (sx < sy) ? 32'd1 : 32'd0;
          6'h2B: r = (x < y) ? 32'd1 : 32'd0;
          6'h10: r = h;
          6'h12: r = l;
          default: r = '0;
        endcase
      end
    endcase
  endfunction

  function automatic void model_muldiv(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                       output logic [31:0] eh, output logic [31:0] el);
    longint      sp;
    logic [63:0] up;
    int          sx, sy;
    sx = x;
    sy = y;
    eh = '0;
    el = '0;
    case (f)
      6'h18: begin sp = longint'(sx) * longint'(sy); {eh, el} = sp; end
      6'h19: begin up = {32'd0, x} * {32'd0, y}; {eh, el} = up; end
      6'h1A: begin
        if (y == 0) begin el = 32'hFFFF_FFFF; eh = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin el = x; eh = 0; end
        else begin el = sx / sy; eh = sx % sy; end
      end
      default: begin
        if (y == 0) begin el = 32'hFFFF_FFFF; eh = x; end
        else begin el = x / y; eh = x % y; end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    @(posedge clk); #1;
    cmp_n++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || stall !== 1'b0) begin
      err_n++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h stall=%b, required all zero", busy, done, hi, lo, stall);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic check_alu(input string name, input logic [1:0] op, input logic [5:0] f,
                           input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    logic        ev;
    model_alu(op, f, x, y, hi, lo, er, ev);
    ALUOp = op; funct = f; a = x; b = y;
    #1;
    cmp_n++;
    if (result !== er || overflow !== ev || zero !== (er == 0)) begin
      err_n++;
      $display("FAIL %s: op=%b f=%h a=%h b=%h got result=%h ovf=%b zero=%b, required result=%h ovf=%b zero=%b",
               name, op, f, x, y, result, overflow, zero, er, ev, (er == 0));
    end
  endtask

  task automatic test_alu_directed();
    @(negedge clk);
    op_valid = 1'b1;
    check_alu("add_ovf",  2'b10, 6'h20, 32'h7FFF_FFFF, 32'h1);
    cmp_n++;
    if (result !== 32'h8000_0000 || overflow !== 1'b1 || zero !== 1'b0) begin
      err_n++;
      $display("FAIL add_ovf_const: result=%h ovf=%b zero=%b, required 80000000 1 0", result, overflow, zero);
    end
    check_alu("addu_noovf", 2'b10, 6'h21, 32'h7FFF_FFFF, 32'h1);
    check_alu("beq_sub",  2'b01, 6'h00, 32'h1234, 32'h1234);
    check_alu("slt",      2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h1);
    check_alu("sltu",     2'b10, 6'h2B, 32'hFFFF_FFFF, 32'h1);
    check_alu("sub_ovf",  2'b10, 6'h22, 32'h8000_0000, 32'h1);
    check_alu("lw_add",   2'b00, 6'h3F, 32'h8000_0000, 32'h8000_0000);
    check_alu("ori",      2'b11, 6'h00, 32'hF0F0_0000, 32'h0000_1234);
    check_alu("undef",    2'b10, 6'h3F, 32'h5555_5555, 32'hAAAA_AAAA);
    op_valid = 1'b0;
  endtask

  task automatic test_alu_random();
    logic [5:0] legal [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B};
    logic [5:0] f;
    logic [1:0] op;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      op = 2'($urandom_range(0, 3));
      f  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal[$urandom_range(0, 15)];
      op_valid = !(op == 2'b10 && f >= 6'h18 && f <= 6'h1B);
      check_alu("alu_random", op, f, pick_opnd(), pick_opnd());
    end
    op_valid = 1'b0;
  endtask

  task automatic run_muldiv(input string name, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    int bad;
    model_muldiv(f, x, y, eh, el);
    @(negedge clk);
    ALUOp = 2'b10; funct = f; a = x; b = y; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    bad = 0;
    for (int c = 1; c <= 33; c++) begin
      if (busy !== 1'b1 || done !== (c == 33)) bad++;
      @(posedge clk); #1;
    end
    cmp_n++;
    if (bad != 0 || busy !== 1'b0 || done !== 1'b0) begin
      err_n++;
      $display("FAIL %s_latency: %0d bad cycles, then busy=%b done=%b; required busy for 33 cycles, done in cycle 33 only",
               name, bad, busy, done);
    end
    cmp_n++;
    if (hi !== eh || lo !== el) begin
      err_n++;
      $display("FAIL %s_hilo: f=%h a=%h b=%h got hi=%h lo=%h, required hi=%h lo=%h", name, f, x, y, hi, lo, eh, el);
    end
    op_valid = 1'b1; funct = 6'h10; #1;
    cmp_n++;
    if (result !== eh || stall !== 1'b0) begin
      err_n++;
      $display("FAIL %s_mfhi: result=%h stall=%b, required %h stall=0", name, result, stall, eh);
    end
    funct = 6'h12; #1;
    cmp_n++;
    if (result !== el) begin
      err_n++;
      $display("FAIL %s_mflo: result=%h, required %h", name, result, el);
    end
    op_valid = 1'b0;
  endtask

  task automatic test_muldiv_directed();
    run_muldiv("mult_neg",  6'h18, 32'hFFFF_FFFE, 32'h3);
    run_muldiv("multu",     6'h19, 32'hFFFF_FFFE, 32'h3);
    run_muldiv("div_neg",   6'h1A, 32'hFFFF_FFF9, 32'h2);
    run_muldiv("divu_zero", 6'h1B, 32'h7, 32'h0);
    run_muldiv("div_zero",  6'h1A, 32'hFFFF_FFF9, 32'h0);
    run_muldiv("div_minm1", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    run_muldiv("mult_min",  6'h18, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_muldiv_random();
    logic [5:0]  f;
    logic [31:0] x, y;
    for (int i = 0; i < 12; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      x = pick_opnd();
      y = ($urandom_range(0, 5) == 0) ? 32'h0 : (($urandom_range(0, 1) == 0) ? pick_opnd() : 32'($urandom_range(1, 1000)));
      run_muldiv("muldiv_random", f, x, y);
    end
  endtask

  task automatic test_stall();
    logic [31:0] x, y, eh, el, ax, ay, er;
    logic        ev;
    int          bad_stall, bad_add;
    x = $urandom | 32'h1;
    y = $urandom | 32'h1;
    model_muldiv(6'h18, x, y, eh, el);
    @(negedge clk);
    ALUOp = 2'b10; funct = 6'h18; a = x; b = y; op_valid = 1'b1;
    @(posedge clk); #1;
    bad_stall = 0;
    bad_add   = 0;
    for (int c = 1; c <= 33; c++) begin
      ALUOp = 2'b10; funct = 6'h12; op_valid = 1'b1; #1;
      if (stall !== 1'b1) bad_stall++;
      ax = $urandom; ay = $urandom;
      model_alu(2'b10, 6'h20, ax, ay, hi, lo, er, ev);
      funct = 6'h20; a = ax; b = ay; #1;
      if (stall !== 1'b0 || result !== er || overflow !== ev) bad_add++;
      funct = 6'h12;
      @(posedge clk); #1;
    end
    cmp_n++;
    if (bad_stall != 0) begin
      err_n++;
      $display("FAIL stall_mflo_busy: %0d cycles without stall, required 0", bad_stall);
    end
    cmp_n++;
    if (bad_add != 0) begin
      err_n++;
      $display("FAIL add_while_busy: %0d cycles wrong, required 0", bad_add);
    end
    cmp_n++;
    if (stall !== 1'b0 || busy !== 1'b0 || result !== el) begin
      err_n++;
      $display("FAIL stall_release: stall=%b busy=%b mflo=%h, required stall=0 busy=0 mflo=%h", stall, busy, result, el);
    end
    op_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ALUOp = 2'b10; funct = 6'h18; a = $urandom | 32'h1; b = $urandom | 32'h1; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; #1;
    cmp_n++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      err_n++;
      $display("FAIL reset_mid_run: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    cmp_n++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      err_n++;
      $display("FAIL reset_release: busy=%b hi=%h lo=%h, required 0", busy, hi, lo);
    end
    run_muldiv("mult_after_reset", 6'h18, 32'hFFFF_FFFE, 32'h3);
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_muldiv_directed();
    test_muldiv_random();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the single-cycle ALU-control decode. Merges ALUOp/funct decode with a WIDTH-bit ALU datapath and an iterative multiply/divide engine that owns HI/LO registers.
- Sits in the EX stage. Single-cycle ops complete combinationally. mult/div run multi-cycle behind a busy/stall handshake to the pipeline control.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 8..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- ALUOp  input  2  00 = add (lw/sw), 01 = sub (beq), 10 = R-type (funct decode), 11 = or (ori)
- funct  input  6  instruction[5:0], used only when ALUOp = 10
- op_valid  input  1  instruction present in EX this cycle
- a  input  WIDTH  operand rs
- b  input  WIDTH  operand rt/imm
- result  output  WIDTH  combinational ALU/mfhi/mflo result
- zero  output  1  result == 0
- overflow  output  1  signed overflow, add/sub only; 0 for all other ops
- stall  output  1  combinational; EX must hold this instruction
- busy  output  1  registered; mult/div engine active
- done  output  1  registered, 1-cycle pulse: HI/LO written at end of this cycle
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Funct decode (ALUOp = 10):
  - 100000 add, 100001 addu, 100010 sub, 100011 subu
  - 100100 and, 100101 or, 100110 xor, 100111 nor
  - 101010 slt (signed), 101011 sltu
  - 010000 mfhi, 010010 mflo
  - 011000 mult, 011001 multu, 011010 div, 011011 divu
  - Any other funct: result = 0, no side effects.
- Arithmetic: all arithmetic is modulo 2^WIDTH. overflow is set only for add/sub (ALUOp 00/01 count as signed add/sub); it is 0 for addu/subu. slt/sltu produce a zero-extended 1 or 0.
- result for mult/div/undefined ops is 0.
- States: IDLE, RUN, FIX.
  - IDLE -> RUN when op_valid && mul/div op && !stall. Latch a/b magnitudes, signs and op, and set count = WIDTH.
  - RUN: each cycle performs one shift-add (mult) or one restoring-subtract step (div), then count--. When count == 1, the next state is FIX.
  - FIX: apply sign correction. done = 1. HI/LO are written at the end of the cycle, then the state returns to IDLE.
  - busy = (state != IDLE).
- Latency: mult/div accepted at edge E; busy is high for WIDTH+1 cycles; done is high in cycle WIDTH+1 after E; new HI/LO are visible from cycle WIDTH+2. For WIDTH = 32 this is 34 cycles issue-to-readable.
- stall = op_valid && busy && (op ∈ {mult, multu, div, divu, mfhi, mflo}). Non-HI/LO ops never stall while busy.
- Results:
  - mult/multu: {hi, lo} = full 2·WIDTH-bit product.
  - div/divu: lo = quotient, hi = remainder. Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: lo = all ones, hi = a (unsigned and signed alike). Completes with normal latency.
  - Signed div of most-negative by −1: lo = most-negative, hi = 0.
- mfhi/mflo read the registers. In IDLE they return the current hi/lo.
- Reset: state = IDLE; hi, lo, count and internal regs = 0; busy = 0; done = 0. Reset mid-RUN/FIX aborts the operation and HI/LO stay 0 after release.
- Combinational outputs (result, zero, overflow, stall) depend only on inputs and registered state, with no input-to-register bypass.

Test Plan:
- Reset, then ALUOp = 10, funct = 100000, a = 0x7FFFFFFF, b = 1 -> result = 0x80000000, overflow = 1, zero = 0. Same operands with funct = 100001 -> overflow = 0.
- ALUOp = 01, a = b = 0x1234 -> result = 0, zero = 1. ALUOp = 10, funct = 101010, a = 0xFFFFFFFF, b = 1 -> result = 1; funct = 101011 -> result = 0.
- mult, a = 0xFFFFFFFE (−2), b = 3 -> busy for 33 cycles, done in cycle 33, then mflo = 0xFFFFFFFA, mfhi = 0xFFFFFFFF. multu with the same operands -> hi = 2, lo = 0xFFFFFFFA.
- div, a = −7, b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. divu with a = 7, b = 0 -> lo = 0xFFFFFFFF, hi = 7.
- While busy: mflo with op_valid -> stall = 1 each cycle until done drops. An add issued in the same window -> stall = 0 and the correct result.
- Assert rst in the 10th RUN cycle of a mult -> busy = 0 and done = 0 immediately, hi = lo = 0. A fresh mult after release completes with full latency.
